// File: rtl/i2s_tx_avalon_if.sv
// Avalon-MM slave bus bundle for i2s_tx_avalon; integration wrappers and benches
// connect its members to the block's flat AVL_* ports.
interface i2s_tx_avalon_if;
    logic        avl_read;
    logic        avl_write;
    logic        avl_cs;
    logic [3:0]  avl_addr;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;

    modport master (
        output avl_read, avl_write, avl_cs, avl_addr, avl_writedata,
        input  avl_readdata
    );

    modport slave (
        input  avl_read, avl_write, avl_cs, avl_addr, avl_writedata,
        output avl_readdata
    );
endinterface

// File: rtl/i2s_tx_avalon.sv
// I2S transmitter / clock master with Avalon-MM control and a stereo sample FIFO.
// Generates SCK and WS from CLK and shifts samples out MSB first on falling SCK.
module i2s_tx_avalon #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned SLOT_BITS  = 32,
    parameter int unsigned DATA_W     = 18,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic        AVL_CS,
    input  logic [3:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    output logic        sck_out,
    output logic        ws_out,
    output logic        sd_out
);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BW = (SLOT_BITS > 1) ? $clog2(2 * SLOT_BITS) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_BITS);
    localparam logic [BW-1:0] WS_LO    = BW'(SLOT_BITS - 1);
    localparam logic [BW-1:0] WS_HI    = BW'(2 * SLOT_BITS - 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e              state_q, state_d;
    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                sck_q, sck_d, ws_q, ws_d, sd_q, sd_d;
    logic [DATA_W-1:0]   shl_q, shl_d, shr_q, shr_d;
    logic                enable_q, enable_d;
    logic                underrun_q, underrun_d, overflow_q, overflow_d;
    logic [DATA_W-1:0]   left_hold_q;

    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q;

    logic wr_en, wr_ctrl, wr_stat, wr_left, push_req, flush;
    logic full, empty, push_ok, ovf_set, pop, underrun_set;
    logic div_wrap, fall_tick, frame_start, drain_end, load, busy;
    logic [BW-1:0]       b_next;
    logic [2*DATA_W-1:0] head;
    logic [DATA_W-1:0]   load_l, load_r;
    logic                unused_wdata;

    assign unused_wdata = ^AVL_WRITEDATA;

    // Bus decode
    assign wr_en    = AVL_CS && AVL_WRITE;
    assign wr_ctrl  = wr_en && (AVL_ADDR == 4'd0);
    assign wr_stat  = wr_en && (AVL_ADDR == 4'd1);
    assign wr_left  = wr_en && (AVL_ADDR == 4'd2);
    assign push_req = wr_en && (AVL_ADDR == 4'd3);
    assign flush    = wr_ctrl && AVL_WRITEDATA[1];
    assign enable_d = wr_ctrl ? AVL_WRITEDATA[0] : enable_q;

    // Serializer timing
    assign busy        = (state_q != S_IDLE);
    assign div_wrap    = busy && (div_cnt_q == DIV_LAST);
    assign fall_tick   = div_wrap && sck_q;
    assign b_next      = (bit_cnt_q == B_LAST) ? '0 : bit_cnt_q + BW'(1);
    assign frame_start = fall_tick && (b_next == '0);
    assign drain_end   = frame_start && (state_q == S_DRAIN) && !enable_q;
    assign load        = frame_start && !drain_end;

    // FIFO control; a pop in the same cycle frees the slot for a push into a full FIFO
    assign full         = (level_q == LW'(FIFO_DEPTH));
    assign empty        = (level_q == '0);
    assign pop          = load && !empty;
    assign underrun_set = load && empty;
    assign push_ok      = push_req && !flush && (!full || pop);
    assign ovf_set      = push_req && !flush && full && !pop;
    assign head         = mem_q[rd_ptr_q];
    assign load_l       = pop ? head[2*DATA_W-1:DATA_W] : '0;
    assign load_r       = pop ? head[DATA_W-1:0] : '0;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {left_hold_q, AVL_WRITEDATA[DATA_W-1:0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a W1C wins
    always_comb begin
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        if (wr_stat && AVL_WRITEDATA[2]) underrun_d = 1'b0;
        if (wr_stat && AVL_WRITEDATA[3]) overflow_d = 1'b0;
        if (underrun_set) underrun_d = 1'b1;
        if (ovf_set)      overflow_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            enable_q    <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            left_hold_q <= '0;
        end else begin
            enable_q   <= enable_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            if (wr_left) left_hold_q <= AVL_WRITEDATA[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sck_d     = sck_q;
        ws_d      = ws_q;
        sd_d      = sd_q;
        shl_d     = shl_q;
        shr_d     = shr_q;
        case (state_q)
            S_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = B_LAST;
                sck_d     = 1'b0;
                ws_d      = 1'b0;
                sd_d      = 1'b0;
                if (enable_d) state_d = S_RUN;
            end
            default: begin
                if ((state_q == S_RUN) && !enable_q)  state_d = S_DRAIN;
                if ((state_q == S_DRAIN) && enable_q) state_d = S_RUN;
                div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
                if (div_wrap) sck_d = ~sck_q;
                if (fall_tick) begin
                    bit_cnt_d = b_next;
                    ws_d      = (b_next >= WS_LO) && (b_next <= WS_HI);
                    if (drain_end) begin
                        state_d   = S_IDLE;
                        div_cnt_d = '0;
                        bit_cnt_d = B_LAST;
                        sck_d     = 1'b0;
                        ws_d      = 1'b0;
                        sd_d      = 1'b0;
                    end else if (b_next == '0) begin
                        sd_d  = load_l[DATA_W-1];
                        shl_d = load_l << 1;
                        shr_d = load_r;
                    end else if (b_next < SLOT_B) begin
                        sd_d  = shl_q[DATA_W-1];
                        shl_d = shl_q << 1;
                    end else begin
                        sd_d  = shr_q[DATA_W-1];
                        shr_d = shr_q << 1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= B_LAST;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            sd_q      <= 1'b0;
            shl_q     <= '0;
            shr_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
            sd_q      <= sd_d;
            shl_q     <= shl_d;
            shr_q     <= shr_d;
        end
    end

    always_comb begin
        AVL_READDATA = '0;
        if (AVL_CS && AVL_READ) begin
            case (AVL_ADDR)
                4'd0: AVL_READDATA[0] = enable_q;
                4'd1: begin
                    AVL_READDATA[0]    = full;
                    AVL_READDATA[1]    = empty;
                    AVL_READDATA[2]    = underrun_q;
                    AVL_READDATA[3]    = overflow_q;
                    AVL_READDATA[15:8] = 8'(level_q);
                    AVL_READDATA[16]   = busy;
                end
                default: AVL_READDATA = '0;
            endcase
        end
    end

    assign sck_out = sck_q;
    assign ws_out  = ws_q;
    assign sd_out  = sd_q;
endmodule

// File: tb/tb_i2s_tx_avalon.sv
// Directed self-checking bench for i2s_tx_avalon at default parameters
// (CLK_DIV=2, SLOT_BITS=32, DATA_W=18, FIFO_DEPTH=8).
module tb_i2s_tx_avalon;
    logic CLK = 1'b0;
    logic RESET;
    logic sck_out, ws_out, sd_out;
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] WS_EXP = {31'h0, 32'hFFFF_FFFF, 1'b0};

    i2s_tx_avalon_if bus ();

    i2s_tx_avalon #(.CLK_DIV(2), .SLOT_BITS(32), .DATA_W(18), .FIFO_DEPTH(8)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .AVL_READ      (bus.avl_read),
        .AVL_WRITE     (bus.avl_write),
        .AVL_CS        (bus.avl_cs),
        .AVL_ADDR      (bus.avl_addr),
        .AVL_WRITEDATA (bus.avl_writedata),
        .AVL_READDATA  (bus.avl_readdata),
        .sck_out       (sck_out),
        .ws_out        (ws_out),
        .sd_out        (sd_out)
    );

    always #5 CLK = ~CLK;

    task automatic avl_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge CLK);
        bus.avl_cs = 1'b1; bus.avl_write = 1'b1; bus.avl_addr = a; bus.avl_writedata = d;
        @(negedge CLK);
        bus.avl_cs = 1'b0; bus.avl_write = 1'b0; bus.avl_addr = '0; bus.avl_writedata = '0;
    endtask

    // Combinational read; consumes no clock edges.
    task automatic avl_read(input logic [3:0] a, output logic [31:0] d);
        bus.avl_cs = 1'b1; bus.avl_read = 1'b1; bus.avl_addr = a;
        #1;
        d = bus.avl_readdata;
        bus.avl_cs = 1'b0; bus.avl_read = 1'b0; bus.avl_addr = '0;
    endtask

    // Wait for the next 1->0 SCK transition, sampled on negedges; cyc = cycles waited.
    task automatic next_fall(output int cyc);
        logic prev;
        prev = sck_out;
        cyc  = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge CLK);
            if (prev && !sck_out) begin
                cyc = i;
                break;
            end
            prev = sck_out;
        end
        if (cyc < 0) begin
            checks++; errors++;
            $display("FAIL sck_fall_timeout: no falling SCK within 64 cycles");
        end
    endtask

    task automatic stop_and_clear();
        logic [31:0] rd;
        bit idle;
        idle = 1'b0;
        avl_write(4'd0, 32'h0);
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            avl_read(4'd1, rd);
            if (!rd[16]) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy still 1 after 600 cycles");
        end
        avl_write(4'd1, 32'hC);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        RESET = 1'b1;
        bus.avl_cs = 1'b0; bus.avl_read = 1'b0; bus.avl_write = 1'b0;
        bus.avl_addr = '0; bus.avl_writedata = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h expected %h", rd, 32'h2); end
        avl_read(4'd0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
        avl_read(4'd2, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL left_reads0: got %h expected 0", rd); end
        checks++; if ({sck_out, ws_out, sd_out} !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b expected 000", {sck_out, ws_out, sd_out}); end
    endtask

    task automatic test_frame();
        logic [31:0] rd;
        logic [63:0] sdv, wsv;
        int cyc, bad;
        avl_write(4'd2, 32'h2A5A5);
        avl_write(4'd3, 32'h15A5A);
        avl_write(4'd0, 32'h1);
        next_fall(cyc);
        checks++; if (cyc != 4) begin errors++; $display("FAIL first_fall_latency: got %0d expected 4", cyc); end
        bad = 0;
        sdv = {63'h0, sd_out}; wsv = {63'h0, ws_out};
        for (int b = 1; b < 64; b++) begin
            next_fall(cyc);
            if (cyc != 4) bad++;
            sdv = {sdv[62:0], sd_out}; wsv = {wsv[62:0], ws_out};
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL sck_period: %0d periods not 4 cycles, expected 0", bad); end
        checks++; if (sdv !== {18'h2A5A5, 14'h0, 18'h15A5A, 14'h0}) begin errors++; $display("FAIL frame1_sd: got %h expected %h", sdv, {18'h2A5A5, 14'h0, 18'h15A5A, 14'h0}); end
        checks++; if (wsv !== WS_EXP) begin errors++; $display("FAIL frame1_ws: got %h expected %h", wsv, WS_EXP); end
        next_fall(cyc);
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0001_0006) begin errors++; $display("FAIL underrun_status: got %h expected %h", rd, 32'h0001_0006); end
        sdv = {63'h0, sd_out}; wsv = {63'h0, ws_out};
        for (int b = 1; b < 64; b++) begin
            next_fall(cyc);
            sdv = {sdv[62:0], sd_out}; wsv = {wsv[62:0], ws_out};
        end
        checks++; if (sdv !== 64'h0) begin errors++; $display("FAIL underrun_frame_sd: got %h expected 0", sdv); end
        checks++; if (wsv !== WS_EXP) begin errors++; $display("FAIL underrun_frame_ws: got %h expected %h", wsv, WS_EXP); end
        stop_and_clear();
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        for (int i = 0; i < 9; i++) begin
            avl_write(4'd2, 32'(i));
            avl_write(4'd3, 32'h100 + 32'(i));
        end
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0000_0809) begin errors++; $display("FAIL overflow_status: got %h expected %h", rd, 32'h809); end
        @(negedge CLK);
        bus.avl_cs = 1'b1; bus.avl_addr = 4'd1;
        #1;
        checks++; if (bus.avl_readdata !== 32'h0) begin errors++; $display("FAIL readdata_no_read: got %h expected 0", bus.avl_readdata); end
        bus.avl_cs = 1'b0; bus.avl_addr = '0;
        avl_write(4'd1, 32'h8);
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0000_0801) begin errors++; $display("FAIL overflow_w1c: got %h expected %h", rd, 32'h801); end
        avl_write(4'd0, 32'h2);
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL idle_flush: got %h expected %h", rd, 32'h2); end
        avl_read(4'd0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL flush_reads0: got %h expected 0", rd); end
    endtask

    task automatic test_push_on_pop();
        logic [31:0] rd;
        logic [63:0] sdv;
        int cyc;
        avl_write(4'd2, 32'h11111); avl_write(4'd3, 32'h22222);
        avl_write(4'd2, 32'h3ABCD); avl_write(4'd3, 32'h01234);
        avl_write(4'd0, 32'h1);
        next_fall(cyc);
        avl_write(4'd2, 32'h2F00F);
        sdv = '0;
        for (int b = 1; b < 64; b++) next_fall(cyc);
        // land the RIGHT write on the posedge of the frame-start pop
        @(negedge CLK); @(negedge CLK);
        avl_write(4'd3, 32'h10FF0);
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0001_0100) begin errors++; $display("FAIL push_pop_level: got %h expected %h", rd, 32'h0001_0100); end
        sdv = {63'h0, sd_out};
        for (int b = 1; b < 64; b++) begin next_fall(cyc); sdv = {sdv[62:0], sd_out}; end
        checks++; if (sdv !== {18'h3ABCD, 14'h0, 18'h01234, 14'h0}) begin errors++; $display("FAIL order_frame_b: got %h expected %h", sdv, {18'h3ABCD, 14'h0, 18'h01234, 14'h0}); end
        next_fall(cyc);
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0001_0002) begin errors++; $display("FAIL last_pop_status: got %h expected %h", rd, 32'h0001_0002); end
        sdv = {63'h0, sd_out};
        for (int b = 1; b < 64; b++) begin next_fall(cyc); sdv = {sdv[62:0], sd_out}; end
        checks++; if (sdv !== {18'h2F00F, 14'h0, 18'h10FF0, 14'h0}) begin errors++; $display("FAIL order_frame_c: got %h expected %h", sdv, {18'h2F00F, 14'h0, 18'h10FF0, 14'h0}); end
        stop_and_clear();
    endtask

    task automatic test_drain();
        logic [31:0] rd;
        logic [63:0] sdv;
        int cyc, bad;
        avl_write(4'd2, 32'h12345); avl_write(4'd3, 32'h3C0F0);
        avl_write(4'd0, 32'h1);
        next_fall(cyc);
        sdv = {63'h0, sd_out};
        bad = 0;
        for (int b = 1; b < 64; b++) begin
            next_fall(cyc);
            sdv = {sdv[62:0], sd_out};
            if (b == 40) avl_write(4'd0, 32'h0);
            if (b > 40) begin avl_read(4'd1, rd); if (!rd[16]) bad++; end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL drain_busy: busy low on %0d bits, expected 0", bad); end
        next_fall(cyc);
        checks++; if (sdv !== {18'h12345, 14'h0, 18'h3C0F0, 14'h0}) begin errors++; $display("FAIL drain_frame: got %h expected %h", sdv, {18'h12345, 14'h0, 18'h3C0F0, 14'h0}); end
        checks++; if ({sck_out, ws_out, sd_out} !== 3'b000) begin errors++; $display("FAIL drain_outputs: got %b expected 000", {sck_out, ws_out, sd_out}); end
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL drain_idle_status: got %h expected %h", rd, 32'h2); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin @(negedge CLK); if (sck_out !== 1'b0) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL sck_stopped: sck high on %0d cycles, expected 0", bad); end

        avl_write(4'd2, 32'h12345); avl_write(4'd3, 32'h3C0F0);
        avl_write(4'd0, 32'h1);
        next_fall(cyc);
        for (int b = 1; b < 64; b++) begin
            next_fall(cyc);
            if (b == 40) avl_write(4'd0, 32'h0);
            if (b == 50) avl_write(4'd0, 32'h1);
        end
        next_fall(cyc);
        checks++; if (cyc != 4) begin errors++; $display("FAIL reenable_gap: wrap period %0d expected 4", cyc); end
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0001_0006) begin errors++; $display("FAIL reenable_status: got %h expected %h", rd, 32'h0001_0006); end
        stop_and_clear();
    endtask

    task automatic test_flush_reset();
        logic [31:0] rd;
        logic [63:0] sdv;
        int cyc;
        avl_write(4'd2, 32'h0F0F0); avl_write(4'd3, 32'h30303);
        for (int k = 1; k < 6; k++) begin
            avl_write(4'd2, 32'h100 + 32'(k));
            avl_write(4'd3, 32'h200 + 32'(k));
        end
        avl_write(4'd0, 32'h1);
        next_fall(cyc);
        sdv = {63'h0, sd_out};
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0001_0500) begin errors++; $display("FAIL pre_flush_level: got %h expected %h", rd, 32'h0001_0500); end
        avl_write(4'd0, 32'h3);
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0001_0002) begin errors++; $display("FAIL run_flush: got %h expected %h", rd, 32'h0001_0002); end
        avl_read(4'd0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_after_flush: got %h expected 1", rd); end
        for (int b = 1; b < 64; b++) begin next_fall(cyc); sdv = {sdv[62:0], sd_out}; end
        checks++; if (sdv !== {18'h0F0F0, 14'h0, 18'h30303, 14'h0}) begin errors++; $display("FAIL flush_frame_intact: got %h expected %h", sdv, {18'h0F0F0, 14'h0, 18'h30303, 14'h0}); end
        next_fall(cyc);
        avl_write(4'd2, 32'h5);
        next_fall(cyc);
        avl_write(4'd3, 32'h6);
        for (int b = 2; b <= 20; b++) next_fall(cyc);
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checks++; if ({sck_out, ws_out, sd_out} !== 3'b000) begin errors++; $display("FAIL midframe_reset_outputs: got %b expected 000", {sck_out, ws_out, sd_out}); end
        avl_read(4'd1, rd);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL midframe_reset_status: got %h expected %h", rd, 32'h2); end
        RESET = 1'b0;
        @(negedge CLK);
        avl_read(4'd0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_ctrl: got %h expected 0", rd); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_overflow();
        test_push_on_pop();
        test_drain();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
